// File: rtl/div_unit_seq_if.sv
// rtl/div_unit_seq_if.sv - request/response signal bundle for the sequential divider
interface div_unit_seq_if #(
    parameter int length = 32
);
    logic [length-1:0] oper_a;
    logic [length-1:0] oper_b;
    logic [1:0]        fuct3;
    logic              enable_div;
    logic [length-1:0] div_o;
    logic              div_finish;
    logic              divided_by_zero;
    logic              div_busy;

    modport master (
        output oper_a, oper_b, fuct3, enable_div,
        input  div_o, div_finish, divided_by_zero, div_busy
    );

    modport slave (
        input  oper_a, oper_b, fuct3, enable_div,
        output div_o, div_finish, divided_by_zero, div_busy
    );
endinterface

// File: rtl/div_unit_seq.sv
// rtl/div_unit_seq.sv - radix-2 restoring divider for DIV/DIVU/REM/REMU
// Optional macro DIV_FAST_ZERO_EN: divide-by-zero and signed overflow bypass the iteration loop.
module div_unit_seq #(
    parameter int length = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    div_unit_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CW = $clog2(length + 1);
    localparam logic [length-1:0] MIN_NEG = {1'b1, {(length-1){1'b0}}};

    state_t            state;
    logic [CW-1:0]     count;
    logic [length-1:0] rem;
    logic [length-1:0] quo;
    logic [length-1:0] b_abs;
    logic [length-1:0] a_raw;
    logic              f_rem;
    logic              q_neg;
    logic              r_neg;
    logic              dz;
    logic              ovf;

    logic              in_signed;
    logic              a_neg;
    logic              b_neg;
    logic [length-1:0] a_mag;
    logic [length-1:0] b_mag;
    logic              is_zero;
    logic              is_ovf;
    logic [length:0]   rem_sh;
    logic [length:0]   diff;
    logic [length-1:0] q_final;
    logic [length-1:0] r_final;
    logic [length-1:0] result;

    always_comb begin
        in_signed = ~bus.fuct3[0];
        a_neg     = in_signed & bus.oper_a[length-1];
        b_neg     = in_signed & bus.oper_b[length-1];
        a_mag     = a_neg ? -bus.oper_a : bus.oper_a;
        b_mag     = b_neg ? -bus.oper_b : bus.oper_b;
        is_zero   = (bus.oper_b == '0);
        is_ovf    = in_signed && (bus.oper_a == MIN_NEG) && (bus.oper_b == '1);
    end

    // One restoring step: the shifted remainder is one bit wider than the operands
    always_comb begin
        rem_sh  = {rem, quo[length-1]};
        diff    = rem_sh - {1'b0, b_abs};
        q_final = q_neg ? -quo : quo;
        r_final = r_neg ? -rem : rem;
        if (dz) begin
            result = f_rem ? a_raw : '1;
        end else if (ovf) begin
            result = f_rem ? '0 : a_raw;
        end else begin
            result = f_rem ? r_final : q_final;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            count               <= '0;
            rem                 <= '0;
            quo                 <= '0;
            b_abs               <= '0;
            a_raw               <= '0;
            f_rem               <= 1'b0;
            q_neg               <= 1'b0;
            r_neg               <= 1'b0;
            dz                  <= 1'b0;
            ovf                 <= 1'b0;
            bus.div_o           <= '0;
            bus.div_finish      <= 1'b0;
            bus.divided_by_zero <= 1'b0;
            bus.div_busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.div_finish <= 1'b0;
                    bus.div_busy   <= 1'b0;
                    // A request seen during the finish pulse is dropped, not deferred
                    if (bus.enable_div && !bus.div_finish) begin
                        a_raw        <= bus.oper_a;
                        quo          <= a_mag;
                        b_abs        <= b_mag;
                        rem          <= '0;
                        count        <= '0;
                        f_rem        <= bus.fuct3[1];
                        q_neg        <= a_neg ^ b_neg;
                        r_neg        <= a_neg;
                        dz           <= is_zero;
                        ovf          <= is_ovf;
                        bus.div_busy <= 1'b1;
`ifdef DIV_FAST_ZERO_EN
                        state        <= (is_zero || is_ovf) ? DONE : CALC;
`else
                        state        <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (!diff[length]) begin
                        rem <= diff[length-1:0];
                        quo <= {quo[length-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[length-1:0];
                        quo <= {quo[length-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(length - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.div_o           <= result;
                    bus.divided_by_zero <= dz;
                    bus.div_finish      <= 1'b1;
                    state               <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit_seq.sv
// tb/tb_div_unit_seq.sv - self-checking bench for div_unit_seq
module tb_div_unit_seq;
    localparam int LEN = 32;
    localparam int SLOW_LAT = LEN + 1;
`ifdef DIV_FAST_ZERO_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = LEN + 1;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  f;
        logic [31:0] exp;
        logic        dz;
        logic        sp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    vec_t tbl [10];

    div_unit_seq_if #(.length(LEN)) bus ();

    div_unit_seq #(.length(LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RISC-V division semantics straight from the arithmetic rules
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                                    output logic [31:0] r, output logic dz, output logic sp);
        int sa, sb;
        logic [31:0] q, m;
        dz = (b == 0);
        sp = dz;
        if (b == 0) begin
            q = '1; m = a;
        end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; m = 0; sp = 1'b1;
        end else if (f[0]) begin
            q = a / b; m = a % b;
        end else begin
            sa = a; sb = b;
            q = sa / sb; m = sa % sb;
        end
        r = f[1] ? m : q;
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
        bus.oper_a = a;
        bus.oper_b = b;
        bus.fuct3 = f;
        bus.enable_div = 1'b1;
        @(posedge clk);
        #1;
        bus.enable_div = 1'b0;
        bus.oper_a = $urandom;
        bus.oper_b = $urandom;
        bus.fuct3 = 2'($urandom);
        chk("busy_after_accept", 32'(bus.div_busy), 32'd1);
    endtask

    task automatic wait_finish(output int lat, output logic ok);
        lat = 0;
        ok = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.div_finish) begin
                lat = i;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("finish_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                          input logic [31:0] exp, input logic exp_dz, input int exp_lat);
        int lat;
        logic ok;
        logic [31:0] held;
        start_op(a, b, f);
        wait_finish(lat, ok);
        if (ok) begin
            chk({name, "_result"}, bus.div_o, exp);
            chk({name, "_dz"}, 32'(bus.divided_by_zero), 32'(exp_dz));
            chk({name, "_latency"}, lat, exp_lat);
            held = bus.div_o;
            @(posedge clk);
            #1;
            chk({name, "_pulse_one_cycle"}, 32'(bus.div_finish), 32'd0);
            chk({name, "_busy_drop"}, 32'(bus.div_busy), 32'd0);
            chk({name, "_held"}, bus.div_o, held);
        end
    endtask

    task automatic watch_idle(input string name, input int cycles);
        int pulses;
        int busy_seen;
        pulses = 0;
        busy_seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.div_finish) pulses++;
            if (bus.div_busy) busy_seen++;
        end
        chk({name, "_no_finish"}, pulses, 0);
        chk({name, "_no_busy"}, busy_seen, 0);
    endtask

    initial begin
        logic [31:0] a, b, r;
        logic [1:0]  f;
        logic        dz, sp;
        int          lat;
        logic        ok;

        n_checks = 0;
        n_fail = 0;
        tbl[0] = '{32'd100,        32'd7,          2'b00, 32'd14,         1'b0, 1'b0};
        tbl[1] = '{-32'sd7,        32'd2,          2'b10, 32'hFFFF_FFFF,  1'b0, 1'b0};
        tbl[2] = '{-32'sd7,        32'd2,          2'b00, 32'hFFFF_FFFD,  1'b0, 1'b0};
        tbl[3] = '{32'hFFFF_FFFF,  32'd2,          2'b01, 32'h7FFF_FFFF,  1'b0, 1'b0};
        tbl[4] = '{32'hFFFF_FFFF,  32'd2,          2'b11, 32'd1,          1'b0, 1'b0};
        tbl[5] = '{32'd5,          32'd0,          2'b00, 32'hFFFF_FFFF,  1'b1, 1'b1};
        tbl[6] = '{32'd5,          32'd0,          2'b10, 32'd5,          1'b1, 1'b1};
        tbl[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  2'b00, 32'h8000_0000,  1'b0, 1'b1};
        tbl[8] = '{32'h8000_0000,  32'hFFFF_FFFF,  2'b10, 32'd0,          1'b0, 1'b1};
        tbl[9] = '{32'd7,          32'd0,          2'b01, 32'hFFFF_FFFF,  1'b1, 1'b1};

        rst_n = 1'b0;
        bus.oper_a = '0;
        bus.oper_b = '0;
        bus.fuct3 = '0;
        bus.enable_div = 1'b0;
        #12;
        chk("reset_div_o", bus.div_o, 32'd0);
        chk("reset_finish", 32'(bus.div_finish), 32'd0);
        chk("reset_dz", 32'(bus.divided_by_zero), 32'd0);
        chk("reset_busy", 32'(bus.div_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].exp, tbl[i].dz,
                   tbl[i].sp ? FAST_LAT : SLOW_LAT);
        end

        for (int i = 0; i < 40; i++) begin
            f = 2'($urandom);
            case ($urandom_range(0, 7))
                0: b = 0;
                1: b = $urandom_range(1, 15);
                2: b = -$urandom_range(1, 15);
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = -$urandom_range(0, 1000);
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            ref_div(a, b, f, r, dz, sp);
            run_op($sformatf("rand%0d", i), a, b, f, r, dz, sp ? FAST_LAT : SLOW_LAT);
        end

        // Request arriving mid-iteration must be dropped
        start_op(32'd100, 32'd7, 2'b00);
        repeat (5) @(posedge clk);
        #1;
        bus.oper_a = 32'd9;
        bus.oper_b = 32'd3;
        bus.fuct3 = 2'b00;
        bus.enable_div = 1'b1;
        @(posedge clk);
        #1;
        bus.enable_div = 1'b0;
        wait_finish(lat, ok);
        if (ok) chk("midcalc_result", bus.div_o, 32'd14);
        watch_idle("midcalc", 40);

        // Request held only during the finish pulse must be dropped
        start_op(32'd50, 32'd5, 2'b01);
        wait_finish(lat, ok);
        if (ok) chk("finpulse_result", bus.div_o, 32'd10);
        bus.oper_a = 32'd77;
        bus.oper_b = 32'd7;
        bus.enable_div = 1'b1;
        @(posedge clk);
        #1;
        bus.enable_div = 1'b0;
        chk("finpulse_not_accepted", 32'(bus.div_busy), 32'd0);
        watch_idle("finpulse", 40);
        chk("finpulse_held", bus.div_o, 32'd10);

        // Abort at iteration 10, then a clean operation
        run_op("pre_abort", 32'd5, 32'd0, 2'b10, 32'd5, 1'b1, FAST_LAT);
        start_op(32'd1000, 32'd3, 2'b00);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_div_o", bus.div_o, 32'd0);
        chk("abort_finish", 32'(bus.div_finish), 32'd0);
        chk("abort_dz", 32'(bus.divided_by_zero), 32'd0);
        chk("abort_busy", 32'(bus.div_busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch_idle("abort", 40);
        run_op("post_abort", 32'd1000, 32'd3, 2'b00, 32'd333, 1'b0, SLOW_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
